radix4_otf_quotient: RTL and testbench
======================================

// Module: radix4_otf_quotient
// PURPOSE
//  Back end of the radix-4 SRT divider: consumes the signed quotient digit stream {-2..+2}
//  emitted by the QDS table, one digit per cycle, and builds the binary quotient by
//  on-the-fly conversion (Q / QM registers), with no carry-propagate add per digit.
//  Applies the final -1 correction when the divider reports a negative final remainder.
//  Sits between the QDS/remainder iteration loop and the divider result mux.
// PARAMETERS
//  NDIGITS  16         number of radix-4 digits per division (counter width = clog2(NDIGITS+1))
//  QW       2*NDIGITS  quotient width in bits; fixed at 2*NDIGITS, never overridden independently
// PORTS
//  clk          in   1    clock, all state updates on rising edge
//  rst_n        in   1    synchronous active-low reset
//  start        in   1    begin new conversion; honoured only in IDLE
//  flush        in   1    abort; returns to IDLE next cycle, no result
//  digit_valid  in   1    digit is valid this cycle
//  digit        in   3    {sign, mag[1:0]}: mag 2'b10=2, 2'b01=1, 2'b00=0; sign=1 means negative
//  digit_ready  out  1    converter accepts a digit (high only in ACCUM)
//  rem_valid    in   1    final remainder sign is valid
//  rem_neg      in   1    final partial remainder is negative -> quotient must be decremented
//  quot_valid   out  1    quotient is valid, held until quot_ready
//  quot_ready   in   1    downstream accepts quotient
//  quotient     out  QW   corrected quotient, two's complement
//  busy         out  1    high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, Q=0, QM=all ones, cnt=0. Outputs: digit_ready=0,
//   quot_valid=0, quotient=0, busy=0. Reset overrides every other input.
//  Decoding: value q = sign ? -mag : mag. Codes mag=2'b11 and 3'b100 are illegal and are
//   decoded as q=0. Both are accepted and counted as normal digits.
//  FSM states are IDLE, ACCUM, WAIT_REM and DONE.
//   IDLE: on start, load Q=0, QM={QW{1'b1}} (-1) and cnt=0, then go to ACCUM.
//   ACCUM: digit_ready=1. A digit is accepted when digit_valid&digit_ready. On accept, cnt++.
//    When the accepted digit is the NDIGITS-th, go to WAIT_REM.
//   WAIT_REM: when rem_valid, register quotient = rem_neg ? QM : Q, then go to DONE.
//   DONE: quot_valid=1. quotient is held stable until quot_valid&quot_ready, then go to IDLE.
//  OTF update per accepted digit (shift left 2, truncate to QW):
//   Q  <= (q>=0) ? {Q[QW-3:0], q[1:0]}       : {QM[QW-3:0], (4+q)[1:0]}
//   QM <= (q>0)  ? {Q[QW-3:0], (q-1)[1:0]}   : {QM[QW-3:0], (3+q)[1:0]}
//   Invariant after every accept: QM == Q-1 mod 2^QW.
//  Latency: last digit accepted at cycle t; rem_valid at t+1 at the earliest; quot_valid at t+2.
//  Throughput: one digit per cycle. Bubbles (digit_valid=0) stall without changing state.
//  Inputs ignored by state:
//   start outside IDLE has no effect.
//   digit_valid outside ACCUM has no effect.
//   rem_valid outside WAIT_REM has no effect.
//  flush in any non-IDLE state: go to IDLE next cycle and drop quot_valid. Q, QM and cnt are
//   not cleared until the next start. flush has priority over start, digit accept, rem_valid
//   and quot_ready in the same cycle.
//  Overflow: the conversion is mod 2^QW; wrap-around is silent, with no flag.
//  Back-to-back operation: start may be asserted in the cycle after the DONE handshake
//   (in IDLE). start in the handshake cycle itself is ignored.
// TESTING
//  T1 NDIGITS=4. Digits +1,+2,-1,0; rem_neg=0 -> quotient=8'h5C.
//     Same digits with rem_neg=1 -> quotient=8'h5B.
//  T2 NDIGITS=4. Digits -1,+2,0,0; rem_neg=0 -> quotient=8'hE0. Check QM==Q-1 after each digit.
//  T3 NDIGITS=4. Digits +2,+2,+2,+2 -> 8'hAA. Digits -2,-2,-2,-2; rem_neg=1 -> 8'h55
//     (wrap-around, no flag).
//  T4 Random bubbles on digit_valid, quot_ready low for 5 cycles: quotient stable, quot_valid
//     held; quot_valid deasserts the cycle after the handshake. Stalls do not change the result.
//  T5 flush after 2 digits -> IDLE, busy=0 next cycle. Then start and a fresh digit stream:
//     result is unaffected by the aborted run. start during ACCUM is ignored.
//  T6 rst_n low in the DONE state -> next cycle quot_valid=0, quotient=0, busy=0.
//     Illegal code 3'b011 is decoded as 0.

Source files
------------

// File: rtl/radix4_otf_quotient.sv
// radix4_otf_quotient: on-the-fly conversion of radix-4 SRT digits
// into a two's complement quotient, with final remainder correction.
module radix4_otf_quotient #(
    parameter int NDIGITS = 16,
    parameter int QW      = 2 * NDIGITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          flush,
    input  logic          digit_valid,
    input  logic [2:0]    digit,
    output logic          digit_ready,
    input  logic          rem_valid,
    input  logic          rem_neg,
    output logic          quot_valid,
    input  logic          quot_ready,
    output logic [QW-1:0] quotient,
    output logic          busy
);

    localparam int CW = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCUM    = 2'd1;
    localparam logic [1:0] WAIT_REM = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [QW-1:0] q_reg;
    logic [QW-1:0] qm_reg;
    logic [QW-1:0] res_reg;
    logic [CW-1:0] cnt;

    logic          abort;
    logic          accept;
    logic          last_dig;
    logic          q_zero;
    logic          q_neg;
    logic          q_pos;
    logic [1:0]    q_bits;
    logic [1:0]    qm_bits;

    assign abort       = flush && (state != IDLE);
    assign digit_ready = (state == ACCUM);
    assign accept      = digit_valid && digit_ready && !flush;
    assign last_dig    = (cnt == LAST);
    assign quot_valid  = (state == DONE);
    assign busy        = (state != IDLE);
    assign quotient    = res_reg;

    // Digit decode; magnitude 3 and negative zero both fold to q=0
    always_comb begin
        q_zero  = (digit[1:0] == 2'b00) || (digit[1:0] == 2'b11);
        q_neg   = digit[2] && !q_zero;
        q_pos   = !digit[2] && !q_zero;
        q_bits  = 2'b00;
        if (!q_zero)
            q_bits = digit[2] ? (2'b00 - digit[1:0]) : digit[1:0];
        qm_bits = q_bits - 2'b01;
    end

    // Next-state selection; abort beats every other event
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (start) state_nxt = ACCUM;
                ACCUM:    if (accept && last_dig) state_nxt = WAIT_REM;
                WAIT_REM: if (rem_valid) state_nxt = DONE;
                DONE:     if (quot_ready) state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Q/QM shift registers and digit counter; left alone on abort
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg  <= '0;
            qm_reg <= '1;
            cnt    <= '0;
        end else if (state == IDLE && start) begin
            q_reg  <= '0;
            qm_reg <= '1;
            cnt    <= '0;
        end else if (accept) begin
            q_reg  <= q_neg ? {qm_reg[QW-3:0], q_bits}
                            : {q_reg[QW-3:0], q_bits};
            qm_reg <= q_pos ? {q_reg[QW-3:0], qm_bits}
                            : {qm_reg[QW-3:0], qm_bits};
            cnt    <= cnt + 1'b1;
        end
    end

    // Result capture; QM is the pre-decremented quotient
    always_ff @(posedge clk) begin
        if (!rst_n)
            res_reg <= '0;
        else if (state == WAIT_REM && rem_valid && !flush)
            res_reg <= rem_neg ? qm_reg : q_reg;
    end

endmodule

// File: tb/tb_radix4_otf_quotient.sv
// tb_radix4_otf_quotient: directed checks of the OTF quotient converter
// with NDIGITS=4 (8-bit quotient).
module tb_radix4_otf_quotient;

    localparam int ND = 4;
    localparam int QW = 2 * ND;

    localparam logic [2:0] P1 = 3'b001;
    localparam logic [2:0] P2 = 3'b010;
    localparam logic [2:0] Z0 = 3'b000;
    localparam logic [2:0] M1 = 3'b101;
    localparam logic [2:0] M2 = 3'b110;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          flush;
    logic          digit_valid;
    logic [2:0]    digit;
    logic          digit_ready;
    logic          rem_valid;
    logic          rem_neg;
    logic          quot_valid;
    logic          quot_ready;
    logic [QW-1:0] quotient;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    radix4_otf_quotient #(.NDIGITS(ND)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .flush       (flush),
        .digit_valid (digit_valid),
        .digit       (digit),
        .digit_ready (digit_ready),
        .rem_valid   (rem_valid),
        .rem_neg     (rem_neg),
        .quot_valid  (quot_valid),
        .quot_ready  (quot_ready),
        .quotient    (quotient),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
        digit       = Z0;
    endtask

    task automatic finish_div(input logic rn, input string tag,
                              input logic [7:0] exp);
        rem_valid = 1'b1;
        rem_neg   = rn;
        tick();
        rem_valid = 1'b0;
        rem_neg   = 1'b0;
        chk({tag, "_qv"}, 32'(quot_valid), 32'd1);
        chk({tag, "_q"}, 32'(quotient), 32'(exp));
        quot_ready = 1'b1;
        tick();
        quot_ready = 1'b0;
        chk({tag, "_qv_drop"}, 32'(quot_valid), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        flush       = 1'b0;
        digit_valid = 1'b0;
        digit       = Z0;
        rem_valid   = 1'b0;
        rem_neg     = 1'b0;
        quot_ready  = 1'b0;
        tick();
        tick();
        chk("rst_qv", 32'(quot_valid), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy", 32'(digit_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // T1: +1,+2,-1,0
        do_start();
        chk("t1_rdy", 32'(digit_ready), 32'd1);
        send(P1); send(P2); send(M1); send(Z0);
        chk("t1_rdy_wait", 32'(digit_ready), 32'd0);
        finish_div(1'b0, "t1a", 8'h5C);
        do_start();
        send(P1); send(P2); send(M1); send(Z0);
        finish_div(1'b1, "t1b", 8'h5B);

        // T2: -1,+2,0,0 with Q/QM tracked per digit
        do_start();
        send(M1);
        chk("t2_q0", 32'(dut.q_reg), 32'h0FF);
        chk("t2_qm0", 32'(dut.qm_reg), 32'h0FE);
        send(P2);
        chk("t2_q1", 32'(dut.q_reg), 32'h0FE);
        chk("t2_qm1", 32'(dut.qm_reg), 32'h0FD);
        send(Z0);
        chk("t2_q2", 32'(dut.q_reg), 32'h0F8);
        chk("t2_qm2", 32'(dut.qm_reg), 32'h0F7);
        send(Z0);
        chk("t2_q3", 32'(dut.q_reg), 32'h0E0);
        chk("t2_qm3", 32'(dut.qm_reg), 32'h0DF);
        finish_div(1'b0, "t2", 8'hE0);

        // T3: saturating digit patterns, wrap-around
        do_start();
        send(P2); send(P2); send(P2); send(P2);
        finish_div(1'b0, "t3a", 8'hAA);
        do_start();
        send(M2); send(M2); send(M2); send(M2);
        finish_div(1'b1, "t3b", 8'h55);

        // T4: bubbles, late remainder, held output
        do_start();
        send(P1);
        tick();
        chk("t4_bub_q", 32'(dut.q_reg), 32'h001);
        chk("t4_bub_rdy", 32'(digit_ready), 32'd1);
        send(P2);
        tick(); tick();
        send(M1);
        tick();
        send(Z0);
        send(P2);
        chk("t4_wait_qv", 32'(quot_valid), 32'd0);
        tick();
        chk("t4_wait_busy", 32'(busy), 32'd1);
        rem_valid = 1'b1;
        tick();
        rem_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_qv", 32'(quot_valid), 32'd1);
            chk("t4_hold_q", 32'(quotient), 32'h05C);
            rem_valid = 1'b1;
            rem_neg   = 1'b1;
            tick();
        end
        rem_valid  = 1'b0;
        rem_neg    = 1'b0;
        chk("t4_hold_q5", 32'(quotient), 32'h05C);
        quot_ready = 1'b1;
        start      = 1'b1;
        tick();
        quot_ready = 1'b0;
        start      = 1'b0;
        chk("t4_hs_qv", 32'(quot_valid), 32'd0);
        chk("t4_hs_busy", 32'(busy), 32'd0);
        chk("t4_hs_q", 32'(quotient), 32'h05C);

        // T5: flush mid-run, start during ACCUM ignored
        do_start();
        send(P2);
        start = 1'b1;
        send(P2);
        start = 1'b0;
        chk("t5_cnt", 32'(dut.cnt), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_fl_busy", 32'(busy), 32'd0);
        chk("t5_fl_rdy", 32'(digit_ready), 32'd0);
        rem_valid = 1'b1;
        tick();
        rem_valid = 1'b0;
        chk("t5_idle_qv", 32'(quot_valid), 32'd0);
        do_start();
        send(M1); send(P2); send(Z0); send(Z0);
        finish_div(1'b0, "t5", 8'hE0);

        // T6: illegal codes, reset while DONE
        do_start();
        send(3'b011); send(P1); send(3'b100); send(Z0);
        rem_valid = 1'b1;
        tick();
        rem_valid = 1'b0;
        chk("t6_q", 32'(quotient), 32'h010);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_rst_qv", 32'(quot_valid), 32'd0);
        chk("t6_rst_q", 32'(quotient), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
